// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 capture path.
package ov7670_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWaitFrame,
    StCapture
  } state_e;

  localparam int unsigned DefHPixels = 640;
  localparam int unsigned DefVLines  = 480;

  // RGB565 field positions within an assembled pixel
  localparam int unsigned RMsb = 15;
  localparam int unsigned RLsb = 11;
  localparam int unsigned GMsb = 10;
  localparam int unsigned GLsb = 5;
  localparam int unsigned BMsb = 4;
  localparam int unsigned BLsb = 0;

endpackage

// File: rtl/ov7670_capture_if.sv
// Camera byte bus in, pixel write stream and frame status out.
interface ov7670_capture_if #(
  parameter int unsigned ADDR_W = 19
) ();
  logic              vsync;
  logic              href;
  logic [7:0]        d;
  logic [15:0]       pix_data;
  logic [ADDR_W-1:0] pix_addr;
  logic              pix_valid;
  logic              frame_done;
  logic              frame_ok;
  logic              busy;

  modport master (
    input  vsync, href, d,
    output pix_data, pix_addr, pix_valid, frame_done, frame_ok, busy
  );

  modport slave (
    output vsync, href, d,
    input  pix_data, pix_addr, pix_valid, frame_done, frame_ok, busy
  );
endinterface

// File: rtl/ov7670_sync_edge.sv
// One-cycle input pipe for camera framing/data with rise/fall strobes on the registered copies.
module ov7670_sync_edge #(
  parameter int unsigned DataWidth = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vsync,
  input  logic                 href,
  input  logic [DataWidth-1:0] d,
  output logic                 vsync_r,
  output logic                 href_r,
  output logic [DataWidth-1:0] d_r,
  output logic                 vsync_rise,
  output logic                 vsync_fall,
  output logic                 href_rise,
  output logic                 href_fall
);
  logic                 vsync_q, vsync_prev_q;
  logic                 href_q, href_prev_q;
  logic [DataWidth-1:0] d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q      <= 1'b0;
      vsync_prev_q <= 1'b0;
      href_q       <= 1'b0;
      href_prev_q  <= 1'b0;
      d_q          <= '0;
    end else begin
      vsync_q      <= vsync;
      vsync_prev_q <= vsync_q;
      href_q       <= href;
      href_prev_q  <= href_q;
      d_q          <= d;
    end
  end

  assign vsync_r    = vsync_q;
  assign href_r     = href_q;
  assign d_r        = d_q;
  assign vsync_rise = vsync_q & ~vsync_prev_q;
  assign vsync_fall = ~vsync_q & vsync_prev_q;
  assign href_rise  = href_q & ~href_prev_q;
  assign href_fall  = ~href_q & href_prev_q;
endmodule

// File: rtl/ov7670_capture.sv
// OV7670 frame capture: VSYNC/HREF framing, RGB565 byte pairing, linear-address pixel writes.
// Define OV7670_CAPTURE_STATS_EN to add err_count / last_line_len outputs.
module ov7670_capture
  import ov7670_pkg::*;
#(
  parameter int unsigned H_PIXELS = DefHPixels,
  parameter int unsigned V_LINES  = DefVLines,
  parameter int unsigned ADDR_W   = 19
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
`ifdef OV7670_CAPTURE_STATS_EN
  output logic [15:0]        err_count,
  output logic [15:0]        last_line_len,
`endif
  ov7670_capture_if.master   bus
);
  localparam int unsigned XW = $clog2(H_PIXELS + 2);
  localparam int unsigned YW = $clog2(V_LINES + 2);
  localparam logic [XW-1:0] HPix = XW'(H_PIXELS);
  localparam logic [YW-1:0] VLin = YW'(V_LINES);

  logic       vsync_r, href_r, vsync_rise, vsync_fall, href_rise, href_fall;
  logic [7:0] d_r;

  ov7670_sync_edge #(.DataWidth(8)) u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .vsync      (bus.vsync),
    .href       (bus.href),
    .d          (bus.d),
    .vsync_r    (vsync_r),
    .href_r     (href_r),
    .d_r        (d_r),
    .vsync_rise (vsync_rise),
    .vsync_fall (vsync_fall),
    .href_rise  (href_rise),
    .href_fall  (href_fall)
  );

  logic unused_sync;
  assign unused_sync = vsync_r ^ href_rise;

  state_e            state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d, pix_addr_q, pix_addr_d;
  logic              phase_q, phase_d, err_q, err_d;
  logic [7:0]        hi_q, hi_d;
  logic [15:0]       pix_data_q, pix_data_d;
  logic              pix_valid_q, pix_valid_d, frame_done_q, frame_done_d;
  logic              frame_ok_q, frame_ok_d;
`ifdef OV7670_CAPTURE_STATS_EN
  logic [15:0]       err_count_q, err_count_d, last_line_len_q, last_line_len_d;
`endif

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    addr_d       = addr_q;
    phase_d      = phase_q;
    err_d        = err_q;
    hi_d         = hi_q;
    pix_data_d   = pix_data_q;
    pix_addr_d   = pix_addr_q;
    pix_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    frame_ok_d   = frame_ok_q;
`ifdef OV7670_CAPTURE_STATS_EN
    err_count_d     = err_count_q;
    last_line_len_d = last_line_len_q;
`endif
    if (!enable) begin
      // Abort: no completion pulse, counters back to zero
      state_d = StIdle;
      x_d     = '0;
      y_d     = '0;
      addr_d  = '0;
      phase_d = 1'b0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: state_d = StWaitFrame;
        StWaitFrame: begin
          if (vsync_fall) begin
            state_d = StCapture;
            x_d     = '0;
            y_d     = '0;
            addr_d  = '0;
            phase_d = 1'b0;
            err_d   = 1'b0;
          end
        end
        StCapture: begin
          if (href_r) begin
            if (!phase_q) begin
              hi_d    = d_r;
              phase_d = 1'b1;
            end else begin
              phase_d = 1'b0;
              if (x_q < HPix && y_q < VLin) begin
                pix_valid_d = 1'b1;
                pix_data_d  = {hi_q, d_r};
                pix_addr_d  = addr_q;
              end else begin
                err_d = 1'b1;
              end
              addr_d = addr_q + ADDR_W'(1);
              if (x_q != '1) x_d = x_q + XW'(1);
            end
          end
          if (href_fall) begin
            if (x_q != HPix || phase_q) err_d = 1'b1;
            if (y_q != '1) y_d = y_q + YW'(1);
            x_d     = '0;
            phase_d = 1'b0;
`ifdef OV7670_CAPTURE_STATS_EN
            last_line_len_d = 16'(x_q);
`endif
          end
          // Evaluated after line-end so a coincident href fall is already counted
          if (vsync_rise) begin
            state_d      = StWaitFrame;
            frame_done_d = 1'b1;
            frame_ok_d   = (y_d == VLin) && !err_d;
`ifdef OV7670_CAPTURE_STATS_EN
            if (!frame_ok_d && err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
`endif
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= '0;
      phase_q      <= 1'b0;
      err_q        <= 1'b0;
      hi_q         <= '0;
      pix_data_q   <= '0;
      pix_addr_q   <= '0;
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
`ifdef OV7670_CAPTURE_STATS_EN
      err_count_q     <= '0;
      last_line_len_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      addr_q       <= addr_d;
      phase_q      <= phase_d;
      err_q        <= err_d;
      hi_q         <= hi_d;
      pix_data_q   <= pix_data_d;
      pix_addr_q   <= pix_addr_d;
      pix_valid_q  <= pix_valid_d;
      frame_done_q <= frame_done_d;
      frame_ok_q   <= frame_ok_d;
`ifdef OV7670_CAPTURE_STATS_EN
      err_count_q     <= err_count_d;
      last_line_len_q <= last_line_len_d;
`endif
    end
  end

  assign bus.pix_data   = pix_data_q;
  assign bus.pix_addr   = pix_addr_q;
  assign bus.pix_valid  = pix_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_ok   = frame_ok_q;
  assign bus.busy       = (state_q == StCapture);
`ifdef OV7670_CAPTURE_STATS_EN
  assign err_count      = err_count_q;
  assign last_line_len  = last_line_len_q;
`endif
endmodule

// File: tb/tb_ov7670_capture.sv
// Directed bench for ov7670_capture (4x3 frame) with pixel/frame scoreboards.
module tb_ov7670_capture;
  localparam int unsigned H = 4;
  localparam int unsigned V = 3;
  localparam int unsigned AW = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
`ifdef OV7670_CAPTURE_STATS_EN
  logic [15:0] err_count, last_line_len;
  int          exp_err_count = 0;
`endif

  ov7670_capture_if #(.ADDR_W(AW)) bus ();

  ov7670_capture #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
`ifdef OV7670_CAPTURE_STATS_EN
    .err_count     (err_count),
    .last_line_len (last_line_len),
`endif
    .bus           (bus)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          exp_addr = 0;
  int          t_mark   = 0;
  bit          lat_armed = 1'b0;
  logic [19:0] q_pix[$];   // {addr, data}
  bit          q_done[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every write and frame completion must match a queued expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.pix_valid === 1'b1) begin
        check("pix_expected", 32'(q_pix.size() != 0), 32'd1);
        if (q_pix.size() != 0) begin
          logic [19:0] e;
          e = q_pix.pop_front();
          check("pix_data", 32'(bus.pix_data), 32'(e[15:0]));
          check("pix_addr", 32'(bus.pix_addr), 32'(e[19:16]));
          if (lat_armed && e[15:0] == 16'hF81F) begin
            check("pix_latency", 32'(cyc - t_mark), 32'd2);
            lat_armed = 1'b0;
          end
        end
      end
      if (bus.frame_done === 1'b1) begin
        check("done_expected", 32'(q_done.size() != 0), 32'd1);
        if (q_done.size() != 0) check("frame_ok", 32'(bus.frame_ok), 32'(q_done.pop_front()));
      end
    end
  end

  task automatic step(input logic v, input logic h, input logic [7:0] b);
    bus.vsync = v;
    bus.href  = h;
    bus.d     = b;
    @(posedge clk);
    #1;
  endtask

  // Byte b of a line: even = high byte, odd = low byte; (1,2) carries 0xF81F
  task automatic send_byte(input int row, input int b, input bit expect_cap);
    int          col;
    logic [7:0]  hi, lo;
    col = b / 2;
    hi  = 8'(row * 16 + col);
    lo  = ~hi;
    if (row == 1 && col == 2) begin
      hi = 8'hF8;
      lo = 8'h1F;
    end
    if (b % 2 == 1) begin
      if (expect_cap && col < int'(H) && row < int'(V))
        q_pix.push_back({4'(exp_addr), hi, lo});
      if (expect_cap) exp_addr++;
      if (row == 1 && col == 2) begin
        t_mark    = cyc;
        lat_armed = expect_cap;
      end
      step(bus.vsync, 1'b1, lo);
    end else begin
      step(bus.vsync, 1'b1, hi);
    end
  endtask

  task automatic send_line(input int row, input int nbytes, input bit expect_cap);
    for (int b = 0; b < nbytes; b++) send_byte(row, b, expect_cap);
    repeat (3) step(bus.vsync, 1'b0, 8'h00);
  endtask

  task automatic frame_start();
    repeat (4) step(1'b1, 1'b0, 8'h00);
    repeat (3) step(1'b0, 1'b0, 8'h00);
    exp_addr = 0;
  endtask

  task automatic run_frame(input int l0, input int l1, input int l2, input bit expect_cap,
                           input bit exp_ok);
    frame_start();
    send_line(0, l0, expect_cap);
    send_line(1, l1, expect_cap);
    send_line(2, l2, expect_cap);
    if (expect_cap) begin
      q_done.push_back(exp_ok);
`ifdef OV7670_CAPTURE_STATS_EN
      if (!exp_ok) exp_err_count++;
`endif
    end
    repeat (4) step(1'b1, 1'b0, 8'h00);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_pix_data"}, 32'(bus.pix_data), 32'd0);
    check({tag, "_pix_addr"}, 32'(bus.pix_addr), 32'd0);
    check({tag, "_pix_valid"}, 32'(bus.pix_valid), 32'd0);
    check({tag, "_frame_done"}, 32'(bus.frame_done), 32'd0);
    check({tag, "_frame_ok"}, 32'(bus.frame_ok), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
`ifdef OV7670_CAPTURE_STATS_EN
    check({tag, "_err_count"}, 32'(err_count), 32'd0);
    check({tag, "_last_line_len"}, 32'(last_line_len), 32'd0);
`endif
  endtask

  initial begin
    #50000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    rst_n     = 1'b1;
    enable    = 1'b0;
    bus.vsync = 1'b0;
    bus.href  = 1'b0;
    bus.d     = 8'h00;
    #1 rst_n  = 1'b0;
    #20;
    check_outputs_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Enable raised mid-frame: the in-flight frame must be ignored entirely
    repeat (4) step(1'b1, 1'b0, 8'h00);
    repeat (3) step(1'b0, 1'b0, 8'h00);
    send_line(0, 8, 1'b0);
    enable = 1'b1;
    send_line(1, 8, 1'b0);
    check("wait_busy", 32'(bus.busy), 32'd0);
    send_line(2, 8, 1'b0);
    run_frame(8, 8, 8, 1'b1, 1'b1);

    // Over-long line then a clean frame
    run_frame(10, 8, 8, 1'b1, 1'b0);
    run_frame(8, 8, 8, 1'b1, 1'b1);
`ifdef OV7670_CAPTURE_STATS_EN
    check("err_count_1", 32'(err_count), 32'(exp_err_count));
`endif

    // Odd byte count on the last line
    run_frame(8, 8, 7, 1'b1, 1'b0);
`ifdef OV7670_CAPTURE_STATS_EN
    check("err_count_2", 32'(err_count), 32'(exp_err_count));
    check("last_line_len", 32'(last_line_len), 32'd3);
`endif

    // Enable dropped after 5 pixels
    frame_start();
    send_line(0, 8, 1'b1);
    send_byte(1, 0, 1'b1);
    send_byte(1, 1, 1'b1);
    send_byte(1, 2, 1'b0);
    check("abort_busy_before", 32'(bus.busy), 32'd1);
    enable = 1'b0;
    send_byte(1, 3, 1'b0);
    check("abort_busy_after", 32'(bus.busy), 32'd0);
    for (int b = 4; b < 8; b++) send_byte(1, b, 1'b0);
    repeat (3) step(1'b0, 1'b0, 8'h00);
    send_line(2, 8, 1'b0);
    repeat (4) step(1'b1, 1'b0, 8'h00);
    check("abort_pix_drained", 32'(q_pix.size()), 32'd0);
    enable = 1'b1;
    run_frame(8, 8, 8, 1'b1, 1'b1);

    // Asynchronous reset between edges in the middle of a captured frame
    frame_start();
    send_line(0, 8, 1'b1);
    check("pre_reset_busy", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    check("reset_pix_drained", 32'(q_pix.size()), 32'd0);
`ifdef OV7670_CAPTURE_STATS_EN
    exp_err_count = 0;
`endif
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_line(1, 8, 1'b0);
    check("post_reset_busy", 32'(bus.busy), 32'd0);
    send_line(2, 8, 1'b0);
    run_frame(8, 8, 8, 1'b1, 1'b1);

    repeat (10) step(1'b1, 1'b0, 8'h00);
    check("final_pix_queue", 32'(q_pix.size()), 32'd0);
    check("final_done_queue", 32'(q_done.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/ov7670_capture.md
Name: ov7670_capture

Overview:
- Downstream stage of the camera configuration block. It runs on the camera pixel clock once the sensor is configured.
- Synchronises to OV7670 VSYNC/HREF framing and assembles two-byte RGB565 pixels from the 8-bit D bus.
- Emits a pixel write stream (data, linear address, valid) toward the frame buffer, plus per-frame completion and status.

Parameters:
- H_PIXELS, 640, active pixels per line
- V_LINES, 480, active lines per frame
- ADDR_W, 19, frame-buffer address width; must satisfy 2^ADDR_W >= H_PIXELS*V_LINES

Ports:
- clk  in  1  camera pixel clock (PCLK); all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  level; driven by configuration done; capture allowed while high
- vsync  in  1  camera VSYNC, high during vertical blanking
- href  in  1  camera HREF, high during active line bytes
- d  in  8  camera data byte
- pix_data  out  16  assembled RGB565 pixel, first byte in [15:8]
- pix_addr  out  ADDR_W  linear address y*H_PIXELS+x
- pix_valid  out  1  one-cycle write strobe
- frame_done  out  1  one-cycle pulse at end of captured frame
- frame_ok  out  1  valid with frame_done; 1 = exact H_PIXELS x V_LINES received
- busy  out  1  high in CAPTURE state

Behaviour:
- Reset values: all outputs 0; state IDLE; internal counters 0; byte phase 0.
- Inputs vsync, href and d are registered once (1-cycle input pipe). Edges of vsync and href are detected on the registered copies.
- States:
  - IDLE: go to WAIT_FRAME when enable=1.
  - WAIT_FRAME: wait for vsync falling edge, then go to CAPTURE. A frame already in progress at enable is never captured partially.
  - CAPTURE: on vsync rising edge go back to WAIT_FRAME and pulse frame_done.
- enable=0 in any state: go to IDLE on the next edge and abort the frame. No frame_done is issued and counters are cleared.
- On entry to CAPTURE: x, y, address counter, byte phase and error flag are all cleared.
- Byte assembly (CAPTURE, registered href=1):
  - Phase 0: latch byte as high byte.
  - Phase 1: form the pixel. pix_data/pix_addr/pix_valid are registered on that same edge, so they are visible in the next cycle.
  - Latency: 2 clk from the second byte on d to pix_valid.
- Per pixel: pix_addr equals the internal address counter, which then increments; x increments.
- If x >= H_PIXELS or y >= V_LINES, the pixel is counted but not written (pix_valid stays 0), and the error flag is set.
- href falling edge (line end):
  - If x != H_PIXELS, or byte phase = 1 (odd byte count, partial pixel dropped), set the error flag.
  - y increments; x and byte phase clear.
  - The address counter is not rewritten: short lines leave subsequent addresses shifted, and the error flag covers this.
- Frame end (vsync rising in CAPTURE): frame_ok = (y == V_LINES) and error flag clear.
- href asserted outside CAPTURE is ignored.
- Simultaneous href fall and vsync rise on the same edge: line-end accounting is applied first, then frame-end evaluation uses the updated y.
- Counter widths: x is clog2(H_PIXELS+2) and saturates at its maximum; y is clog2(V_LINES+2) and saturates. No wrap.

Optional Feature:
- Macro OV7670_CAPTURE_STATS_EN.
- When defined, add outputs:
  - err_count[15:0]: increments on each frame_done with frame_ok=0, saturating at 0xFFFF.
  - last_line_len[15:0]: x value latched at each href fall.
  - Both reset to 0.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package ov7670_pkg:
  - state enum (IDLE, WAIT_FRAME, CAPTURE)
  - RGB565 field positions (R [15:11], G [10:5], B [4:0])
  - default frame constants 640/480
- One natural sub-module: ov7670_sync_edge. Registers vsync/href/d and outputs the delayed copies plus rise/fall strobes. It is used by this block and reusable elsewhere.

Test Plan (H_PIXELS=4, V_LINES=3, ADDR_W=4):
- enable=1 mid-frame (vsync low), lines streaming -> no pix_valid until the next vsync fall; then 12 writes at addresses 0..11, frame_done with frame_ok=1.
- Byte pair 0xF8,0x1F -> pix_data=0xF81F with pix_valid exactly 2 clk after the 0x1F byte; pixel at row 1, col 2 gives pix_addr=6.
- Line with 5 pixels -> 5th pixel not written, frame_ok=0; next frame correct -> frame_ok=1 (err_count=1 with STATS_EN).
- Line with 7 bytes -> partial byte dropped, that line yields 3 writes, frame_ok=0.
- enable dropped after 5 pixels -> busy=0 next cycle, no frame_done; re-enable -> the next full frame starts again at address 0.
- Async rst_n low mid-CAPTURE, between edges -> all outputs 0 immediately; after release, frame capture is gated on enable and a fresh vsync fall.
